alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Round-robin grant, registered operands, captured result held until consumed.
module alu_arbiter #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req1_valid,
   output logic              req0_ready,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [SEL_W-1:0]  req0_sel,
   input  logic [SEL_W-1:0]  req1_sel,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   output logic              resp0_valid,
   output logic              resp1_valid,
   input  logic              resp0_ready,
   input  logic              resp1_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_carry,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   logic   ptr;
   logic   owner;
   logic   grant1;
   logic   accept;
   logic   done;

   // Pointer only breaks ties; a lone requester always wins.
   always_comb begin
      grant1 = 1'b0;
      if (req0_valid && req1_valid)
         grant1 = ptr;
      else
         grant1 = req1_valid;
   end

   assign accept = (state == IDLE) && !rst
                   && (req0_valid || req1_valid);

   assign req0_ready = accept && !grant1;
   assign req1_ready = accept && grant1;

   assign resp0_valid = (state == RESP) && !owner;
   assign resp1_valid = (state == RESP) && owner;

   assign done = (state == RESP)
                 && (owner ? resp1_ready : resp0_ready);

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= 1'b0;
         owner      <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         resp_data  <= '0;
         resp_carry <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  alu_a   <= grant1 ? req1_a : req0_a;
                  alu_b   <= grant1 ? req1_b : req0_b;
                  alu_sel <= grant1 ? req1_sel : req0_sel;
                  owner   <= grant1;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               resp_data  <= alu_out;
               resp_carry <= alu_carry;
               state      <= RESP;
            end
            RESP: begin
               if (done) begin
                  ptr   <= ~owner;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
